// File: rtl/risc_pkg.sv
// Shared definitions for the word-addressed RISC core pipeline.
package risc_pkg;

    localparam logic [31:0] RISC_NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] RISC_RESET_PC  = 32'h0000_0000;
    localparam int          RISC_MEM_DEPTH = 128;

    // Fetch-stage state: FAULT is entered after the first out-of-range capture
    typedef enum logic {
        FS_RUN   = 1'b0,
        FS_FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC select: branch target beats stall-hold, which beats PC+1.
module pc_next_sel (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_inc,
    output logic [31:0] pc_next
);

    // Sequential successor wraps naturally at 2^32
    assign pc_inc = pc + 32'd1;

    // Priority mux for the next program counter
    always_comb begin
        pc_next = pc_inc;
        if (branch_taken)
            pc_next = branch_target;
        else if (stall)
            pc_next = pc;
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC register, combinational imem address, IF/ID register and
// sticky out-of-range fault tracking.
module instr_fetch_stage
    import risc_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RISC_RESET_PC,
    parameter int          MEM_DEPTH = RISC_MEM_DEPTH,
    parameter logic [31:0] NOP_WORD  = RISC_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_npc,
    output logic        if_id_valid,
    output logic        fetch_fault
);

    logic [31:0]  pc_inc;
    logic [31:0]  pc_next;
    logic         in_range;
    logic         fetch_adv;
    fetch_state_t state;

    pc_next_sel u_pc_next_sel (
        .pc            (pc),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_inc        (pc_inc),
        .pc_next       (pc_next)
    );

    assign mem_addr  = pc;
    assign in_range  = (pc < 32'(MEM_DEPTH));
    // A normal fetch edge: neither redirected nor held
    assign fetch_adv = !branch_taken && !stall;

    // PC register; hold and redirect are already folded into pc_next
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

    // IF/ID register: flush on branch, freeze on stall, capture otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_instr <= NOP_WORD;
            if_id_npc   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (branch_taken) begin
            if_id_instr <= NOP_WORD;
            if_id_npc   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_npc <= pc_inc;
            if (in_range) begin
                if_id_instr <= mem_data;
                if_id_valid <= 1'b1;
            end else begin
                // mem_data is undefined out of range; insert a bubble instead
                if_id_instr <= NOP_WORD;
                if_id_valid <= 1'b0;
            end
        end
    end

    // Fault FSM: one-way RUN -> FAULT on an out-of-range capture, exit only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FS_RUN;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                FS_RUN: begin
                    if (fetch_adv && !in_range) begin
                        state       <= FS_FAULT;
                        fetch_fault <= 1'b1;
                    end
                end
                FS_FAULT: begin
                    fetch_fault <= 1'b1;
                end
                default: begin
                    state       <= FS_RUN;
                    fetch_fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a combinational memory model.
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] WA  = 32'hA000_000A;
    localparam logic [31:0] WB  = 32'hB000_000B;
    localparam logic [31:0] WC  = 32'hC000_000C;
    localparam logic [31:0] WD  = 32'hD000_000D;
    localparam logic [31:0] WX  = 32'h5800_0020;
    localparam logic [31:0] W5  = 32'h0505_0505;
    localparam logic [31:0] W127 = 32'h7F7F_7F7F;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        if_id_valid;
    logic        fetch_fault;

    logic [31:0] mem [0:127];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Out-of-range reads return junk so a missing range check is visible
    assign mem_data = (mem_addr < 32'd128) ? mem[mem_addr[6:0]] : (32'hBAD0_0000 ^ mem_addr);

    instr_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_npc     (if_id_npc),
        .if_id_valid   (if_id_valid),
        .fetch_fault   (fetch_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Full snapshot of the visible state
    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_npc, input logic e_valid, input logic e_fault);
        chk({tag, ".pc"},    pc,          e_pc);
        chk({tag, ".addr"},  mem_addr,    e_pc);
        chk({tag, ".instr"}, if_id_instr, e_instr);
        chk({tag, ".npc"},   if_id_npc,   e_npc);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
        chk({tag, ".fault"}, {31'd0, fetch_fault}, {31'd0, e_fault});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = WA; mem[1] = WB; mem[2] = WC; mem[3] = WD;
        mem[5] = W5; mem[20] = WX; mem[127] = W127;

        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        #3;
        chk_all("reset", 32'd0, NOP, 32'd0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0;

        // 1: sequential fetch
        step(); chk_all("seq1", 32'd1, WA, 32'd1, 1'b1, 1'b0);
        step(); chk_all("seq2", 32'd2, WB, 32'd2, 1'b1, 1'b0);

        // 2: stall for three cycles holding B / pc 2
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); chk_all("stall", 32'd2, WB, 32'd2, 1'b1, 1'b0);
        end
        stall = 1'b0;
        step(); chk_all("resumeC", 32'd3, WC, 32'd3, 1'b1, 1'b0);
        step(); chk_all("seqD", 32'd4, WD, 32'd4, 1'b1, 1'b0);

        // 3: branch redirect to 20
        branch_taken = 1'b1; branch_target = 32'd20;
        step(); chk_all("br_n1", 32'd20, NOP, 32'd0, 1'b0, 1'b0);
        branch_taken = 1'b0;
        step(); chk_all("br_n2", 32'd21, WX, 32'd21, 1'b1, 1'b0);

        // 4: branch together with stall; branch wins
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd5;
        step(); chk_all("brstall", 32'd5, NOP, 32'd0, 1'b0, 1'b0);
        branch_taken = 1'b0;
        step(); chk_all("brstall_hold", 32'd5, NOP, 32'd0, 1'b0, 1'b0);
        stall = 1'b0;
        step(); chk_all("brstall_go", 32'd6, W5, 32'd6, 1'b1, 1'b0);

        // 5: out-of-range fetch at 128
        branch_taken = 1'b1; branch_target = 32'd127;
        step(); chk_all("oor_br", 32'd127, NOP, 32'd0, 1'b0, 1'b0);
        branch_taken = 1'b0;
        step(); chk_all("oor_127", 32'd128, W127, 32'd128, 1'b1, 1'b0);
        step(); chk_all("oor_128", 32'd129, NOP, 32'd129, 1'b0, 1'b1);
        branch_taken = 1'b1; branch_target = 32'd3;
        step(); chk_all("fault_br", 32'd3, NOP, 32'd0, 1'b0, 1'b1);
        branch_taken = 1'b0;
        step(); chk_all("fault_sticky", 32'd4, WD, 32'd4, 1'b1, 1'b1);

        // 6a: asynchronous reset between edges with pc = 9
        branch_taken = 1'b1; branch_target = 32'd9;
        step(); chk("pc9", pc, 32'd9);
        branch_taken = 1'b0;
        #2; rst = 1'b1; #1;
        chk_all("async_rst", 32'd0, NOP, 32'd0, 1'b0, 1'b0);
        step(); chk_all("rst_held", 32'd0, NOP, 32'd0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0;
        step(); chk_all("post_rst", 32'd1, WA, 32'd1, 1'b1, 1'b0);

        // 6b: wrap from 32'hFFFF_FFFF
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        step(); chk_all("wrap_br", 32'hFFFF_FFFF, NOP, 32'd0, 1'b0, 1'b0);
        branch_taken = 1'b0;
        step(); chk_all("wrap0", 32'd0, NOP, 32'd0, 1'b0, 1'b1);
        step(); chk_all("wrapA", 32'd1, WA, 32'd1, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Pipeline fetch stage for the word-addressed RISC core: holds the program counter, drives the combinational instruction memory address, and captures the returned word into the IF/ID pipeline register. It sits directly upstream of the instruction memory and directly upstream of decode. It handles sequential fetch, stall-hold and taken-branch redirect with bubble insertion.

## Interface
- `RESET_PC`, default 0: PC value loaded on reset (word index).
- `MEM_DEPTH`, default 128: number of valid instruction words; PCs at or above this are out of range.
- `NOP_WORD`, default 32'h0000_0000: instruction word inserted as a bubble.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `stall`  in  1: hazard unit hold request; freezes the PC and IF/ID.
- `branch_taken`  in  1: redirect request from the branch-resolve stage.
- `branch_target`  in  32: word index to fetch next when `branch_taken` is high.
- `mem_addr`  out  32: address to instruction memory; equals the current PC, combinational.
- `mem_data`  in  32: instruction word returned combinationally for `mem_addr`.
- `pc`  out  32: current PC.
- `if_id_instr`  out  32: latched instruction.
- `if_id_npc`  out  32: latched PC+1 of that instruction.
- `if_id_valid`  out  1: latched instruction is real (not a bubble).
- `fetch_fault`  out  1: sticky flag; set when an out-of-range PC was fetched.

## Operation
- Addressing is in words. The sequential next PC is PC+1, modulo 2^32. PC 32'hFFFF_FFFF wraps to 0.
- Reset values:
  - `pc` = `RESET_PC`
  - `if_id_instr` = `NOP_WORD`
  - `if_id_npc` = 0
  - `if_id_valid` = 0
  - `fetch_fault` = 0
- Per-edge priority is rst > branch_taken > stall > normal.
- **branch_taken = 1**
  - PC <= `branch_target`.
  - IF/ID is flushed: instr = `NOP_WORD`, npc = 0, valid = 0.
  - This applies even when `stall` is also high; the branch wins.
- **stall = 1, branch_taken = 0**
  - PC, IF/ID and `fetch_fault` all hold their values.
- **Normal** (both low)
  - PC <= PC+1.
  - if_id_npc <= PC+1.
  - If PC < `MEM_DEPTH`: if_id_instr <= `mem_data` and if_id_valid <= 1.
  - Otherwise: if_id_instr <= `NOP_WORD`, if_id_valid <= 0, and `fetch_fault` <= 1.
- The `mem_data` value is ignored whenever the PC is out of range; the memory is not required to behave sensibly there.
- `fetch_fault` clears only on `rst`.
- The state machine has two states:
  - RUN: normal, branch and stall handling as above.
  - FAULT: entered on the first out-of-range capture. Behaviour is identical to RUN apart from `fetch_fault` = 1, so that decode and debug can observe it.
  - FAULT exits only via `rst`.

## Timing
- `mem_addr` follows `pc` with zero cycles of latency; the memory read is combinational within the cycle.
- Fetch latency is one cycle. The word at PC in cycle n is visible on `if_id_instr` from cycle n+1.
- A branch asserted in cycle n produces:
  - cycle n+1: `pc` = target, IF/ID holds a bubble;
  - cycle n+2: first target instruction is valid on IF/ID.
- The branch penalty is exactly 1 bubble.
- Stall held for k cycles freezes all outputs for k cycles. The next edge after `stall` falls resumes normal operation with no lost and no duplicated instruction.
- Asynchronous `rst` mid-operation forces all reset values immediately, independent of `clk`.
- Reset release is synchronised by design practice upstream. The first fetch edge after release captures the word at `RESET_PC`.

## Structure
- Shared package `risc_pkg` holds:
  - `NOP_WORD`
  - the default `RESET_PC`
  - the default `MEM_DEPTH`
  - the 2-state fetch-state enum (`FS_RUN`, `FS_FAULT`)
- Natural sub-module `pc_next_sel`: combinational next-PC select (target / hold / PC+1) with the priority above.
- The PC register, IF/ID register and fault FSM live in `instr_fetch_stage`.

## Test plan
1. **Reset and sequential fetch.** Memory[0..3] = A,B,C,D, `rst` pulsed. Expected:
   - `if_id_instr` sequence NOP, A, B, C, D;
   - `if_id_npc` sequence 0, 1, 2, 3, 4;
   - `if_id_valid` goes 0 then 1.
2. **Stall hold.** Assert `stall` for 3 cycles while `if_id_instr` = B, `pc` = 2. Expected:
   - outputs frozen at B / 2 for 3 cycles;
   - the next capture is C, with no C duplicated and no C skipped.
3. **Branch redirect.** In cycle n set `branch_taken` = 1, target = 20, with memory[20] = X. Expected:
   - cycle n+1: `pc` = 20, valid = 0, instr = NOP;
   - cycle n+2: instr = X, npc = 21.
4. **Branch during stall.** Assert `stall` and `branch_taken` together, target = 5. Expected:
   - PC = 5 and IF/ID flushed;
   - the stall has no effect on that edge.
5. **Out-of-range fetch.** Branch to 127, then run 2 cycles. Expected:
   - word 127 is captured valid;
   - the PC=128 capture gives valid = 0, instr = NOP, `fetch_fault` = 1;
   - `fetch_fault` stays 1 until `rst`.
6. **Asynchronous reset and wrap.** First, assert `rst` between clock edges while `pc` = 9. Then separately branch to 32'hFFFF_FFFF. Expected:
   - on `rst`: `pc` = 0 immediately;
   - after the branch: the next sequential PC is 0.
